// File: rtl/moving_window_pkg.sv
// Shared constants and helpers for the moving-window sum datapath.
package moving_window_pkg;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 64;
  // Windows deeper than this use a circular buffer instead of a shift register.
  localparam int SHIFT_REG_MAX_DEPTH = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/window_delay_line.sv
// Holds the last DEPTH accepted samples and exposes the one about to leave the window.
// Shift register for shallow windows, circular buffer for deep ones; both zero on reset/clear.
module window_delay_line
  import moving_window_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] oldest
);

  generate
    if (DEPTH <= SHIFT_REG_MAX_DEPTH) begin : g_shift
      logic [WIDTH-1:0] taps [DEPTH];

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else if (shift_en) begin
          taps[0] <= din;
          for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
      end

      assign oldest = taps[DEPTH-1];
    end else begin : g_circ
      localparam int PTR_W = clog2(DEPTH);

      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
          wr_ptr <= '0;
        end else if (shift_en) begin
          mem[wr_ptr] <= din;
          wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
      end

      // The slot about to be overwritten holds the sample leaving the window.
      assign oldest = mem[wr_ptr];
    end
  endgenerate

endmodule

// File: rtl/moving_window_sum.sv
// Sliding-window sum of the last DEPTH accepted samples, with power-of-two average.
// One-cycle latency; a sample is accepted on any edge with d_valid=1 (reset > clear > d_valid).
module moving_window_sum
  import moving_window_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 3,
  parameter int SUM_WIDTH = 10,
  parameter int AVG_SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            d,
  input  logic                        d_valid,
  input  logic                        clear,
  output logic [SUM_WIDTH-1:0]        sum,
  output logic [WIDTH-1:0]            avg,
  output logic [clog2(DEPTH+1)-1:0]   sample_count,
  output logic                        window_full
);

  localparam int CNT_W = clog2(DEPTH + 1);

  generate
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("moving_window_sum: DEPTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0]     oldest;
  logic [SUM_WIDTH-1:0] d_ext;
  logic [SUM_WIDTH-1:0] oldest_ext;

  // Sized casts zero-extend, or truncate when SUM_WIDTH < WIDTH (a legal, lossy setting).
  assign d_ext      = SUM_WIDTH'(d);
  assign oldest_ext = SUM_WIDTH'(oldest);

  window_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_delay_line (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (d_valid),
    .din      (d),
    .oldest   (oldest)
  );

  // Modular add/subtract keeps sum exact even after it wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (d_valid) begin
      sum <= sum + d_ext - oldest_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sample_count <= '0;
    end else if (d_valid && !window_full) begin
      sample_count <= sample_count + CNT_W'(1);
    end
  end

  assign window_full = (sample_count == CNT_W'(DEPTH));
  assign avg         = WIDTH'(sum >> AVG_SHIFT);

endmodule

// File: tb/tb_moving_window_sum.sv
// Drives five parameterisations with one stimulus stream and scores them against a window model.
module tb_moving_window_sum;

  localparam int NDUT = 5;
  localparam int unsigned DEP [NDUT] = '{3, 3, 4, 16, 1};
  localparam int unsigned SW  [NDUT] = '{10, 8, 10, 12, 8};
  localparam int unsigned SH  [NDUT] = '{0, 0, 2, 0, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       d_valid = 1'b0;
  logic [7:0] d = 8'd0;

  logic [9:0]  sum_a;  logic [7:0] avg_a;  logic [1:0] cnt_a;  logic full_a;
  logic [7:0]  sum_b;  logic [7:0] avg_b;  logic [1:0] cnt_b;  logic full_b;
  logic [9:0]  sum_c;  logic [7:0] avg_c;  logic [2:0] cnt_c;  logic full_c;
  logic [11:0] sum_d;  logic [7:0] avg_d;  logic [4:0] cnt_d;  logic full_d;
  logic [7:0]  sum_e;  logic [7:0] avg_e;  logic [0:0] cnt_e;  logic full_e;

  always #5 clk = ~clk;

  moving_window_sum #(.WIDTH(8), .DEPTH(3), .SUM_WIDTH(10), .AVG_SHIFT(0)) u_a (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clear(clear),
    .sum(sum_a), .avg(avg_a), .sample_count(cnt_a), .window_full(full_a));
  moving_window_sum #(.WIDTH(8), .DEPTH(3), .SUM_WIDTH(8), .AVG_SHIFT(0)) u_b (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clear(clear),
    .sum(sum_b), .avg(avg_b), .sample_count(cnt_b), .window_full(full_b));
  moving_window_sum #(.WIDTH(8), .DEPTH(4), .SUM_WIDTH(10), .AVG_SHIFT(2)) u_c (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clear(clear),
    .sum(sum_c), .avg(avg_c), .sample_count(cnt_c), .window_full(full_c));
  moving_window_sum #(.WIDTH(8), .DEPTH(16), .SUM_WIDTH(12), .AVG_SHIFT(0)) u_d (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clear(clear),
    .sum(sum_d), .avg(avg_d), .sample_count(cnt_d), .window_full(full_d));
  moving_window_sum #(.WIDTH(8), .DEPTH(1), .SUM_WIDTH(8), .AVG_SHIFT(0)) u_e (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clear(clear),
    .sum(sum_e), .avg(avg_e), .sample_count(cnt_e), .window_full(full_e));

  typedef struct packed {
    logic [NDUT-1:0][31:0] sum;
    logic [NDUT-1:0][31:0] cnt;
    logic [NDUT-1:0][7:0]  avg;
    logic [NDUT-1:0]       full;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] hist[$];
  int         checks = 0;
  int         errors = 0;
  string      phase = "reset";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e = '0;
    for (int k = 0; k < NDUT; k++) begin
      int unsigned n;
      logic [31:0] s;
      n = (hist.size() < DEP[k]) ? hist.size() : DEP[k];
      s = 32'd0;
      for (int i = 0; i < int'(n); i++) s = s + 32'(hist[i]);
      s = s & ((32'd1 << SW[k]) - 32'd1);
      e.sum[k]  = s;
      e.cnt[k]  = n;
      e.full[k] = (n == DEP[k]);
      e.avg[k]  = 8'((s >> SH[k]) & 32'hFF);
    end
    return e;
  endfunction

  function automatic logic [31:0] got_sum(input int k);
    case (k)
      0: return 32'(sum_a);
      1: return 32'(sum_b);
      2: return 32'(sum_c);
      3: return 32'(sum_d);
      default: return 32'(sum_e);
    endcase
  endfunction

  function automatic logic [31:0] got_cnt(input int k);
    case (k)
      0: return 32'(cnt_a);
      1: return 32'(cnt_b);
      2: return 32'(cnt_c);
      3: return 32'(cnt_d);
      default: return 32'(cnt_e);
    endcase
  endfunction

  function automatic logic [7:0] got_avg(input int k);
    case (k)
      0: return avg_a;
      1: return avg_b;
      2: return avg_c;
      3: return avg_d;
      default: return avg_e;
    endcase
  endfunction

  function automatic logic got_full(input int k);
    case (k)
      0: return full_a;
      1: return full_b;
      2: return full_c;
      3: return full_d;
      default: return full_e;
    endcase
  endfunction

  // One clock: drive at negedge, predict, then compare just after the posedge.
  task automatic step(input logic v, input logic [7:0] din, input logic clr, input logic rst);
    exp_t e;
    @(negedge clk);
    d_valid = v;
    d       = din;
    clear   = clr;
    reset   = rst;
    if (rst || clr) begin
      hist.delete();
    end else if (v) begin
      hist.push_front(din);
      if (hist.size() > 64) void'(hist.pop_back());
    end
    sb.push_back(model());
    @(posedge clk);
    #1;
    check_val("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int k = 0; k < NDUT; k++) begin
        check_val($sformatf("sum[%0d]", k), got_sum(k), e.sum[k]);
        check_val($sformatf("cnt[%0d]", k), got_cnt(k), e.cnt[k]);
        check_val($sformatf("avg[%0d]", k), 32'(got_avg(k)), 32'(e.avg[k]));
        check_val($sformatf("full[%0d]", k), 32'(got_full(k)), 32'(e.full[k]));
      end
    end
  endtask

  task automatic accept(input logic [7:0] din);
    step(1'b1, din, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : main
    logic [7:0] lfsr;
    logic [9:0] t1_sum [5];
    logic [1:0] t1_cnt [5];
    t1_sum = '{10'd10, 10'd30, 10'd60, 10'd90, 10'd120};
    t1_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    do_reset();
    check_val("rst_sum", 32'(sum_a), 32'd0);
    check_val("rst_avg", 32'(avg_a), 32'd0);
    check_val("rst_cnt", 32'(cnt_a), 32'd0);
    check_val("rst_full", 32'(full_a), 32'd0);

    phase = "fill";
    for (int i = 0; i < 5; i++) begin
      accept(8'(10 * (i + 1)));
      check_val("t1_sum", 32'(sum_a), 32'(t1_sum[i]));
      check_val("t1_cnt", 32'(cnt_a), 32'(t1_cnt[i]));
      check_val("t1_full", 32'(full_a), (i >= 2) ? 32'd1 : 32'd0);
    end
    check_val("t1_depth1", 32'(sum_e), 32'd50);

    phase = "valid_gap";
    do_reset();
    step(1'b1, 8'd5, 1'b0, 1'b0);  check_val("t3_sum", 32'(sum_a), 32'd5);
    step(1'b0, 8'd99, 1'b0, 1'b0); check_val("t3_sum", 32'(sum_a), 32'd5);
    step(1'b0, 8'd99, 1'b0, 1'b0); check_val("t3_cnt", 32'(cnt_a), 32'd1);
    step(1'b1, 8'd7, 1'b0, 1'b0);  check_val("t3_sum", 32'(sum_a), 32'd12);
    check_val("t3_cnt", 32'(cnt_a), 32'd2);

    phase = "clear";
    do_reset();
    for (int r = 0; r < 2; r++) begin
      accept(8'd20); accept(8'd30); accept(8'd40);
      check_val("t4_fill", 32'(sum_a), 32'd90);
      step(1'b1, 8'd77, (r == 0), (r == 1));
      check_val("t4_sum", 32'(sum_a), 32'd0);
      check_val("t4_cnt", 32'(cnt_a), 32'd0);
      check_val("t4_full", 32'(full_a), 32'd0);
      accept(8'd1);
      check_val("t4_after", 32'(sum_a), 32'd1);
      phase = "mid_reset";
    end

    phase = "wrap";
    do_reset();
    accept(8'd200); check_val("t2_sum", 32'(sum_b), 32'd200);
    accept(8'd100); check_val("t2_sum", 32'(sum_b), 32'd44);
    accept(8'd50);  check_val("t2_sum", 32'(sum_b), 32'd94);
    accept(8'd0);   check_val("t2_sum", 32'(sum_b), 32'd150);
    phase = "lfsr";
    lfsr = 8'hA5;
    for (int i = 0; i < 256; i++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      accept(lfsr);
    end

    phase = "avg";
    do_reset();
    accept(8'd4); accept(8'd8); accept(8'd12); accept(8'd16);
    check_val("t5_sum", 32'(sum_c), 32'd40);
    check_val("t5_avg", 32'(avg_c), 32'd10);
    accept(8'd20);
    check_val("t5_sum", 32'(sum_c), 32'd56);
    check_val("t5_avg", 32'(avg_c), 32'd14);

    phase = "random";
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 63) == 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
